// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared state encoding and B3/S23 cell rule for the life array scanner
package life_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] BIRTH      = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  function automatic logic next_cell(input logic cur, input logic [3:0] count);
    logic res;
    if (cur) res = (count >= SURVIVE_LO) && (count <= SURVIVE_HI);
    else     res = (count == BIRTH);
    return res;
  endfunction

endpackage

// File: rtl/life_neighbour_count.sv
// rtl/life_neighbour_count.sv - live-neighbour count of one cell, optional toroidal wrap
module life_neighbour_count
  import life_pkg::*;
#(
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int N    = ROWS * COLS,
  localparam int IW   = $clog2(N)
) (
  input  logic [N-1:0]  i_alive,
  input  logic [RW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  input  logic          i_wrap_en,
  output logic [3:0]    o_count
);

  always_comb begin
    int            nr;
    int            nc;
    logic          valid;
    logic [IW-1:0] nidx;
    o_count = '0;
    nr      = 0;
    nc      = 0;
    valid   = 1'b0;
    nidx    = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr    = int'(i_row) + dr;
        nc    = int'(i_col) + dc;
        valid = !((dr == 0) && (dc == 0));
        // Off-grid neighbours either wrap to the opposite edge or are dropped.
        if (nr < 0) begin
          nr    = ROWS - 1;
          valid = valid && i_wrap_en;
        end else if (nr >= ROWS) begin
          nr    = 0;
          valid = valid && i_wrap_en;
        end
        if (nc < 0) begin
          nc    = COLS - 1;
          valid = valid && i_wrap_en;
        end else if (nc >= COLS) begin
          nc    = 0;
          valid = valid && i_wrap_en;
        end
        nidx = IW'(nr * COLS + nc);
        if (valid) o_count = o_count + {3'b000, i_alive[nidx]};
      end
    end
  end

endmodule

// File: rtl/life_array_scan.sv
// rtl/life_array_scan.sv - Game-of-Life grid updated one cell per clock into a shadow, committed atomically
module life_array_scan
  import life_pkg::*;
#(
  parameter  int ROWS  = 4,
  parameter  int COLS  = 4,
  parameter  int GEN_W = 16,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int N     = ROWS * COLS,
  localparam int PW    = $clog2(N + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [RW-1:0]    i_row,
  input  logic [CW-1:0]    i_col,
  input  logic             i_val,
  input  logic             i_write_enb,
  input  logic             i_start,
  input  logic             i_run,
  input  logic             i_wrap_en,
  output logic [N-1:0]     o_alive,
  output logic             o_busy,
  output logic             o_done,
  output logic [GEN_W-1:0] o_gen_count,
  output logic [PW-1:0]    o_pop,
  output logic             o_stable
);

  localparam int IW = $clog2(N);

  state_t           r_state;
  state_t           w_next_state;
  logic [N-1:0]     r_alive;
  logic [N-1:0]     r_shadow;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [IW-1:0]    r_idx;
  logic             r_wrap;
  logic             r_done;
  logic [GEN_W-1:0] r_gen;
  logic [PW-1:0]    r_pop;
  logic             r_stable;

  logic [3:0]       w_count;
  logic             w_last;
  logic             w_wr_ok;
  logic [IW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_pop;

  life_neighbour_count #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_count (
    .i_alive   (r_alive),
    .i_row     (r_row),
    .i_col     (r_col),
    .i_wrap_en (r_wrap),
    .o_count   (w_count)
  );

  assign w_last   = (r_idx == IW'(N - 1));
  assign w_wr_ok  = (int'(i_row) < ROWS) && (int'(i_col) < COLS);
  assign w_wr_idx = IW'(int'(i_row) * COLS + int'(i_col));

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) w_pop = w_pop + PW'(r_shadow[i]);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start || i_run) w_next_state = SCAN;
      SCAN:    if (w_last) w_next_state = COMMIT;
      COMMIT:  w_next_state = i_run ? SCAN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_alive  <= '0;
      r_shadow <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_idx    <= '0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_gen    <= '0;
      r_pop    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_write_enb && w_wr_ok) r_alive[w_wr_idx] <= i_val;
          if (i_start || i_run) r_wrap <= i_wrap_en;
        end
        SCAN: begin
          r_shadow[r_idx] <= next_cell(r_alive[r_idx], w_count);
          // The row/col pair steps alongside the flat index so no divider is needed.
          if (w_last) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
          end else begin
            r_idx <= r_idx + IW'(1);
            if (int'(r_col) == COLS - 1) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        COMMIT: begin
          r_alive  <= r_shadow;
          r_pop    <= w_pop;
          r_stable <= (r_shadow == r_alive);
          r_gen    <= r_gen + GEN_W'(1);
          r_done   <= 1'b1;
          if (i_run) r_wrap <= i_wrap_en;
        end
        default: ;
      endcase
    end
  end

  assign o_alive     = r_alive;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_gen_count = r_gen;
  assign o_pop       = r_pop;
  assign o_stable    = r_stable;

endmodule

// File: tb/tb_life_array_scan.sv
// tb/tb_life_array_scan.sv - directed and random checks of life_array_scan against a grid model
module tb_life_array_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  row;
  logic [1:0]  col;
  logic        val, we, start, run, wrap;
  logic [15:0] alive;
  logic        busy, done, stable;
  logic [15:0] gen;
  logic [4:0]  pop;

  logic [1:0]  row2;
  logic [2:0]  col2;
  logic        val2, we2, start2, run2, wrap2;
  logic [14:0] alive2;
  logic        busy2, done2, stable2;
  logic [15:0] gen2;
  logic [3:0]  pop2;

  int errors = 0;
  int checks = 0;

  life_array_scan #(.ROWS(4), .COLS(4), .GEN_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_row(row), .i_col(col), .i_val(val),
    .i_write_enb(we), .i_start(start), .i_run(run), .i_wrap_en(wrap),
    .o_alive(alive), .o_busy(busy), .o_done(done), .o_gen_count(gen),
    .o_pop(pop), .o_stable(stable)
  );

  life_array_scan #(.ROWS(3), .COLS(5), .GEN_W(16)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_row(row2), .i_col(col2), .i_val(val2),
    .i_write_enb(we2), .i_start(start2), .i_run(run2), .i_wrap_en(wrap2),
    .o_alive(alive2), .o_busy(busy2), .o_done(done2), .o_gen_count(gen2),
    .o_pop(pop2), .o_stable(stable2)
  );

  // One Game-of-Life generation on a rows x cols grid held row-major in a 64-bit word.
  function automatic logic [63:0] life_step(input logic [63:0] g, input int rows,
                                            input int cols, input bit wr);
    logic [63:0] nx;
    nx = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wr) begin
              rr = (rr + rows) % rows;
              cc = (cc + cols) % cols;
            end else if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) begin
              continue;
            end
            if (g[rr * cols + cc]) n++;
          end
        end
        nx[r * cols + c] = (n == 3) || (g[r * cols + c] && n == 2);
      end
    end
    return nx;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write1(input int r, input int c, input bit v);
    row = 2'(r); col = 2'(c); val = v; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic write2(input int r, input int c, input bit v);
    row2 = 2'(r); col2 = 3'(c); val2 = v; we2 = 1'b1;
    step();
    we2 = 1'b0;
  endtask

  task automatic load1(input logic [15:0] g);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) write1(r, c, g[r * 4 + c]);
  endtask

  task automatic load2(input logic [14:0] g);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) write2(r, c, g[r * 5 + c]);
  endtask

  // Steps until the chosen instance pulses done; lat counts edges, bounded at 200.
  task automatic wait_done(input bit which, output int lat, output int busy_low);
    lat = 0;
    busy_low = 0;
    do begin
      step();
      lat++;
      if (!(which ? busy2 : busy) && !(which ? done2 : done)) busy_low++;
    end while (!(which ? done2 : done) && lat < 200);
  endtask

  task automatic gen1(input bit w, output int lat);
    int bl;
    wrap = w; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1'b0, lat, bl);
  endtask

  task automatic gen_dut2(input bit w, output int lat);
    int bl;
    wrap2 = w; start2 = 1'b1;
    step();
    start2 = 1'b0;
    wait_done(1'b1, lat, bl);
  endtask

  initial begin
    int          lat, bl, ndone, gexp;
    logic [15:0] g, m;
    logic [14:0] g2, m2;
    bit          w;

    rst = 1'b1;
    row = '0; col = '0; val = 1'b0; we = 1'b0; start = 1'b0; run = 1'b0; wrap = 1'b0;
    row2 = '0; col2 = '0; val2 = 1'b0; we2 = 1'b0; start2 = 1'b0; run2 = 1'b0; wrap2 = 1'b0;
    gexp = 0;
    step();
    step();
    check("rst_alive", alive, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gen", gen, 0);
    check("rst_pop", pop, 0);
    check("rst_stable", stable, 0);
    check("rst_alive2", alive2, 0);
    rst = 1'b0;
    step();

    // Toad
    write1(1, 0, 1'b1);
    check("write_visible", alive, 16'h0010);
    write1(2, 0, 1'b1); write1(3, 1, 1'b1); write1(0, 2, 1'b1);
    write1(1, 3, 1'b1); write1(2, 3, 1'b1);
    check("toad_seed", alive, 16'h2994);
    gen1(1'b0, lat);
    gexp++;
    check("toad_latency", lat, 17);
    check("toad_busy_at_done", busy, 0);
    check("toad_alive", alive, 16'h07E0);
    check("toad_model", alive, life_step(64'h2994, 4, 4, 1'b0));
    check("toad_pop", pop, 6);
    check("toad_gen", gen, 1);
    check("toad_stable", stable, 0);
    step();
    check("toad_done_single", done, 0);

    // Edge blinker with and without wrap
    load1(16'h000B);
    gen1(1'b1, lat);
    gexp++;
    check("blink_wrap_alive", alive, 16'h1011);
    check("blink_wrap_pop", pop, 3);
    load1(16'h000B);
    gen1(1'b0, lat);
    gexp++;
    check("blink_nowrap_alive", alive, 16'h0000);
    check("blink_nowrap_pop", pop, 0);

    // Block still life
    load1(16'h0660);
    gen1(1'b0, lat);
    gexp++;
    check("block_alive", alive, 16'h0660);
    check("block_stable", stable, 1);
    check("block_pop", pop, 4);
    check("block_gen", gen, gexp);

    // Random grids against the model
    for (int k = 0; k < 6; k++) begin
      g = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      load1(g);
      gen1(w, lat);
      gexp++;
      m = 16'(life_step(64'(g), 4, 4, w));
      check("rand_alive", alive, m);
      check("rand_pop", pop, $countones(m));
      check("rand_stable", stable, m == g);
      check("rand_gen", gen, gexp);
      check("rand_latency", lat, 17);
    end

    // Continuous run on the toad
    load1(16'h2994);
    wrap = 1'b0;
    run = 1'b1;
    step();
    check("run_busy_start", busy, 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) run = 1'b0;
      wait_done(1'b0, lat, bl);
      gexp++;
      check("run_alive", alive, (k % 2 == 0) ? 16'h07E0 : 16'h2994);
      check("run_period", lat, 17);
      check("run_no_idle_gap", bl, 0);
      check("run_busy_at_done", busy, (k < 3) ? 1 : 0);
      check("run_gen", gen, gexp);
    end
    step();
    check("run_idle_after_drop", busy, 0);

    // Write and start during SCAN are ignored
    g = 16'($urandom);
    load1(g);
    wrap = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    row = 2'd2; col = 2'd1; val = ~g[9]; we = 1'b1; start = 1'b1;
    step();
    we = 1'b0; start = 1'b0;
    check("busy_write_ignored", alive, g);
    check("busy_still_busy", busy, 1);
    wait_done(1'b0, lat, bl);
    gexp++;
    check("busy_latency", lat + 5, 17);
    check("busy_alive", alive, life_step(64'(g), 4, 4, 1'b0));
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) ndone++;
    end
    check("busy_no_extra_gen", ndone, 0);
    check("busy_gen", gen, gexp);
    check("busy_idle", busy, 0);

    // 3x5 build: out-of-range writes, then random generations
    write2(3, 0, 1'b1);
    write2(0, 5, 1'b1);
    write2(2, 7, 1'b1);
    check("oor_writes_ignored", alive2, 0);
    write2(2, 4, 1'b1);
    check("inrange_write", alive2, 15'h4000);
    for (int k = 0; k < 4; k++) begin
      g2 = 15'($urandom);
      w = 1'(k % 2);
      load2(g2);
      gen_dut2(w, lat);
      m2 = 15'(life_step(64'(g2), 3, 5, w));
      check("r35_alive", alive2, m2);
      check("r35_pop", pop2, $countones(m2));
      check("r35_latency", lat, 16);
      check("r35_gen", gen2, k + 1);
    end

    // Reset during scan at idx 7
    load1(16'h2994);
    wrap = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_alive", alive, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_gen", gen, 0);
    check("abort_pop", pop, 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done || busy) ndone++;
    end
    check("abort_no_commit", ndone, 0);
    check("abort_gen_after", gen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/life_array_scan.md
# life_array_scan

Parametrised Game-of-Life array with a sequential scan update engine. Holds a ROWS×COLS cell grid, and accepts single-cell writes while idle. On request it computes one generation by visiting one cell per clock into a shadow buffer, then commits the whole grid atomically. It adds toroidal wrap, continuous run, a generation counter, population count and still-life detection.

## Interface
- ROWS, 4, grid rows (≥2)
- COLS, 4, grid columns (≥2)
- GEN_W, 16, generation counter width
- RW / CW, derived: max(1,$clog2(ROWS)) / max(1,$clog2(COLS))
- N, derived: ROWS*COLS; PW, derived: $clog2(N+1)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears grid and all state
- row  in  RW  write row index
- col  in  CW  write column index
- val  in  1  value written
- write_enb  in  1  write strobe, honoured only in IDLE
- start  in  1  request one generation, honoured only in IDLE
- run  in  1  level; when high, generations repeat back-to-back
- wrap_en  in  1  1 = toroidal edges, 0 = cells beyond edges are dead; sampled at start
- alive  out  N  grid, bit index row*COLS+col
- busy  out  1  high in SCAN/COMMIT
- done  out  1  one-cycle pulse after each commit
- gen_count  out  GEN_W  committed generations, wraps modulo 2^GEN_W
- pop  out  PW  live-cell count of committed grid
- stable  out  1  last commit produced no change

## Operation
- States: IDLE, SCAN, COMMIT. Reset → IDLE. All outputs and the shadow buffer reset to 0.
- IDLE: if write_enb and row<ROWS and col<COLS, alive[row*COLS+col]←val. Out-of-range writes are ignored.
- IDLE and (start or run): latch wrap_en, set idx←0, → SCAN.
  - A write in the same cycle lands first and is included in the generation.
- SCAN: each cycle, compute shadow[idx] from the frozen alive with rule B3/S23 over 8 neighbours.
  - wrap_en=0: off-grid neighbours count as 0.
  - wrap_en=1: indices wrap modulo ROWS/COLS.
  - Neighbour count is 4 bits.
  - idx runs 0..N-1 in row-major order. At idx=N-1 → COMMIT.
- COMMIT (single cycle):
  - alive←shadow; pop←popcount(shadow); stable←(shadow==alive); gen_count←gen_count+1; done←1 next cycle.
  - Then run=1 → SCAN with idx←0, re-sampling wrap_en. Otherwise → IDLE.
- write_enb and start while busy are ignored and not queued. alive never changes during SCAN.
- Reset in any state aborts the generation, with no partial commit.

## Timing
- Edge E0 samples start. SCAN occupies edges E1..EN, and COMMIT is edge EN+1.
- alive, pop, stable and gen_count are valid after EN+1. done is high for the cycle after EN+1.
- Latency is N+1 cycles, which is 17 for 4×4.
- busy is high from after E0 through the COMMIT cycle.
  - In run mode busy stays high continuously, and the generation period is N+1 cycles.
- A write appears on alive the cycle after write_enb.

## Structure
- Package life_pkg holds:
  - the state enum (IDLE/SCAN/COMMIT);
  - function next_cell(cur, count) implementing B3/S23;
  - constants BIRTH=3, SURVIVE_LO=2, SURVIVE_HI=3.
- One sub-module, life_neighbour_count: combinational.
  - Inputs: alive vector, row/col of idx, wrap_en.
  - Output: 4-bit count.
  - Parametrised by ROWS/COLS.
- Top level: FSM, idx counter (row/col pair, not a divider), shadow register, popcount, generation counter.

## Test plan
- Toad, 4×4, wrap_en=0: write (1,0),(2,0),(3,1),(0,2),(1,3),(2,3) → alive=16'h2994. Pulse start → after 17 cycles alive=16'h07E0, pop=6, gen_count=1, stable=0, one done pulse.
- Edge blinker: alive=16'h000B.
  - wrap_en=1, start → alive=16'h1011.
  - Same seed with wrap_en=0 → alive=16'h0000, pop=0.
- Block still life 16'h0660, start → alive unchanged, stable=1, pop=4, gen_count increments.
- run=1 on toad: alive alternates 16'h07E0/16'h2994 every 17 cycles with no idle gap. busy stays 1. gen_count increments on every commit. Drop run → returns to IDLE after the current commit.
- write_enb and start asserted mid-SCAN are ignored: alive, busy and gen_count are unaffected and there is no extra generation. A write with row=ROWS-1+1 in IDLE is ignored (ROWS non-power-of-2 build, e.g. ROWS=3, COLS=5).
- Reset asserted at scan idx=7: next cycle alive=0, busy=0, done=0, gen_count=0, pop=0, state IDLE. No commit occurs.
